// File: rtl/box_sort_classifier.sv
// Box-size classifier: averages 2^NSAMP_LOG2 ultrasonic echo counts per laser-armed window and lights one band LED.
// Optional per-class tally counters are enabled by defining BOX_TALLY_EN.
module box_sort_classifier #(
  parameter int              CW          = 20,
  parameter int              NSAMP_LOG2  = 2,
  parameter logic [CW-1:0]   L1_MIN      = 20'd14000,
  parameter logic [CW-1:0]   L1_MAX      = 20'd23000,
  parameter logic [CW-1:0]   L2_MIN      = 20'd23500,
  parameter logic [CW-1:0]   L2_MAX      = 20'd30500,
  parameter logic [CW-1:0]   L3_MIN      = 20'd31000,
  parameter logic [CW-1:0]   L3_MAX      = 20'd38000,
  parameter int              HOLD_CYC    = 25_000_000,
  parameter int              TIMEOUT_CYC = 5_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          laser,
  input  logic [CW-1:0] count,
  input  logic          count_valid,
  output logic          rled,
  output logic          vled,
  output logic          aled,
  output logic          xled,
  output logic          class_valid,
  output logic          timeout_err,
`ifdef BOX_TALLY_EN
  input  logic [2:0]    tally_sel,
  input  logic          tally_clr,
  output logic [15:0]   tally,
`endif
  output logic          busy
);

  localparam int SW = CW + NSAMP_LOG2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SAMPLE   = 2'd1;
  localparam logic [1:0] CLASSIFY = 2'd2;
  localparam logic [1:0] HOLD     = 2'd3;

  logic [1:0]            state;
  logic                  laser_meta, laser_sync, laser_prev;
  logic                  laser_edge;
  logic [SW-1:0]         sum;
  logic [NSAMP_LOG2-1:0] samp_cnt;
  logic [TW-1:0]         timer;
  logic [HW-1:0]         hold_cnt;
  logic [CW-1:0]         avg;
  logic [3:0]            leds;       // {x, a, v, r}
  logic [3:0]            class_leds;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      laser_meta <= 1'b0;
      laser_sync <= 1'b0;
      laser_prev <= 1'b0;
    end else begin
      laser_meta <= laser;
      laser_sync <= laser_meta;
      laser_prev <= laser_sync;
    end
  end

  assign laser_edge = laser_sync & ~laser_prev;
  assign avg        = sum[SW-1:NSAMP_LOG2];

  // Reject has priority over the bands; gaps between bands light nothing.
  always_comb begin
    class_leds = 4'b0000;
    if (avg >= L3_MAX)                      class_leds = 4'b1000;
    else if (avg > L1_MIN && avg < L1_MAX)  class_leds = 4'b0001;
    else if (avg > L2_MIN && avg < L2_MAX)  class_leds = 4'b0010;
    else if (avg > L3_MIN && avg < L3_MAX)  class_leds = 4'b0100;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sum         <= '0;
      samp_cnt    <= '0;
      timer       <= '0;
      hold_cnt    <= '0;
      leds        <= 4'b0000;
      class_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (laser_edge) begin
            state       <= SAMPLE;
            sum         <= '0;
            samp_cnt    <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
          end
        end
        SAMPLE: begin
          // A strobe on the expiry cycle still counts and restarts the timer.
          if (count_valid) begin
            sum   <= sum + {{NSAMP_LOG2{1'b0}}, count};
            timer <= '0;
            if (&samp_cnt) state <= CLASSIFY;
            else           samp_cnt <= samp_cnt + 1'b1;
          end else if (timer == TO_LAST) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            leds        <= 4'b0000;
            class_valid <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CLASSIFY: begin
          state       <= HOLD;
          hold_cnt    <= '0;
          leds        <= class_leds;
          class_valid <= 1'b1;
        end
        HOLD: begin
          if (laser_edge) begin
            state       <= SAMPLE;
            leds        <= 4'b0000;
            sum         <= '0;
            samp_cnt    <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state <= IDLE;
            leds  <= 4'b0000;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rled = leds[0];
  assign vled = leds[1];
  assign aled = leds[2];
  assign xled = leds[3];
  assign busy = (state != IDLE);

`ifdef BOX_TALLY_EN
  // Counter order: r, v, a, x, none, timeout.
  logic [15:0] tally_cnt [6];
  logic [2:0]  tally_idx;

  always_comb begin
    tally_idx = 3'd4;
    if (timeout_err)  tally_idx = 3'd5;
    else if (leds[0]) tally_idx = 3'd0;
    else if (leds[1]) tally_idx = 3'd1;
    else if (leds[2]) tally_idx = 3'd2;
    else if (leds[3]) tally_idx = 3'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) tally_cnt[i] <= '0;
    end else if (tally_clr) begin
      for (int i = 0; i < 6; i++) tally_cnt[i] <= '0;
    end else if (class_valid && tally_cnt[tally_idx] != 16'hffff) begin
      tally_cnt[tally_idx] <= tally_cnt[tally_idx] + 16'd1;
    end
  end

  always_comb begin
    tally = '0;
    if (tally_sel < 3'd6) tally = tally_cnt[tally_sel];
  end
`endif

endmodule
